// File: rtl/amba_apb_master.sv
// amba_apb_master: APB3/APB4 requester. It turns single-word client commands
// into APB SETUP/ACCESS transfers on a 16-bit address / 32-bit data bus.
// Each transfer returns a one-cycle response pulse carrying read data, the
// slave error and the timeout status.
//
// Ports:
//   apb_clk, apb_rst_n        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       client command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata/strb command payload
//   rsp_valid                 one-cycle response pulse
//   rsp_rdata/err/timeout     response fields, held between pulses
//   busy                      state != IDLE (combinational)
//   PADDR..PENABLE            APB requester outputs (registered)
//   PRDATA, PREADY, PSLVERR   APB completer inputs
module amba_apb_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        apb_clk,
    input  logic        apb_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_strb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [15:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    output logic        PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // A TIMEOUT of 0 disables the abort path.
    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;

    // Ready in IDLE, or in the completing ACCESS cycle for back-to-back issue.
    assign cmd_ready = (state == ST_IDLE) | ((state == ST_ACCESS) & PREADY);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;

            // Command latch is shared by the IDLE and back-to-back accepts.
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                PSTRB  <= cmd_write ? cmd_strb : 4'b0000;
            end

            case (state)
                ST_IDLE: begin
                    PENABLE <= 1'b0;
                    if (cmd_valid) begin
                        state <= ST_SETUP;
                        PSEL  <= 1'b1;
                    end else begin
                        PSEL  <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    state    <= ST_ACCESS;
                    PSEL     <= 1'b1;
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                end

                ST_ACCESS: begin
                    if (PREADY) begin
                        // Normal completion takes priority over the timeout.
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
                        PENABLE     <= 1'b0;
                        if (cmd_valid) begin
                            state <= ST_SETUP;
                            PSEL  <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            PSEL  <= 1'b0;
                        end
                    end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                        state       <= ST_IDLE;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_amba_apb_master.sv
// Directed bench for amba_apb_master (TIMEOUT=4). Inputs change and outputs
// are sampled on the falling edge of apb_clk.
module tb_amba_apb_master;

    logic        apb_clk;
    logic        apb_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int vectors;
    int miscompares;

    amba_apb_master #(.TIMEOUT(4), .CNT_W(8)) dut (
        .apb_clk    (apb_clk),
        .apb_rst_n  (apb_rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    task automatic test_reset();
        apb_rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0;
        cmd_wdata = 32'h0; cmd_strb = 4'h0;
        PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        repeat (2) @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, PWRITE, busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {PSEL, PENABLE, PWRITE, busy});
        end
        vectors++;
        if ({PADDR, PWDATA, PSTRB} !== 52'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got %h expected 0", {PADDR, PWDATA, PSTRB});
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) begin
            miscompares++;
            $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata});
        end
        apb_rst_n = 1'b1;
        @(negedge apb_clk);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0010;
        cmd_wdata = 32'hDEADBEEF; cmd_strb = 4'hF;
        PREADY = 1'b1; PRDATA = 32'h5555AAAA; PSLVERR = 1'b0;
        vectors++;
        if ({cmd_ready, PSEL} !== 2'b10) begin
            miscompares++;
            $display("FAIL wr_idle: got %b expected 10", {cmd_ready, PSEL});
        end
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        vectors++;
        if ({PSEL, PENABLE, PWRITE} !== 3'b101) begin
            miscompares++;
            $display("FAIL wr_setup_ctrl: got %b expected 101", {PSEL, PENABLE, PWRITE});
        end
        vectors++;
        if ({PADDR, PWDATA, PSTRB} !== {16'h0010, 32'hDEADBEEF, 4'hF}) begin
            miscompares++;
            $display("FAIL wr_setup_bus: got %h expected 0010deadbeeff", {PADDR, PWDATA, PSTRB});
        end
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, rsp_valid, PWDATA} !== {3'b110, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL wr_access: got %h expected %h", {PSEL, PENABLE, rsp_valid, PWDATA}, {3'b110, 32'hDEADBEEF});
        end
        @(negedge apb_clk);
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0}) begin
            miscompares++;
            $display("FAIL wr_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0});
        end
        vectors++;
        if ({PSEL, PENABLE, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL wr_idle_after: got %b expected 000", {PSEL, PENABLE, busy});
        end
        @(negedge apb_clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rsp_pulse: got %b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_waits();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0024;
        cmd_wdata = 32'h01020304; cmd_strb = 4'hF;
        PREADY = 1'b0; PRDATA = 32'h0;
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        vectors++;
        if ({PSEL, PENABLE, PWRITE, PSTRB} !== 7'b100_0000) begin
            miscompares++;
            $display("FAIL rd_setup: got %b expected 1000000", {PSEL, PENABLE, PWRITE, PSTRB});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge apb_clk);
            vectors++;
            if ({PSEL, PENABLE, PADDR, rsp_valid} !== {2'b11, 16'h0024, 1'b0}) begin
                miscompares++;
                $display("FAIL rd_access%0d: got %h expected %h", i, {PSEL, PENABLE, PADDR, rsp_valid}, {2'b11, 16'h0024, 1'b0});
            end
            if (i == 2) begin
                PREADY = 1'b1; PRDATA = 32'h12345678;
            end
        end
        @(negedge apb_clk);
        PREADY = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL} !== {3'b100, 32'h12345678, 1'b0}) begin
            miscompares++;
            $display("FAIL rd_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata, PSEL}, {3'b100, 32'h12345678, 1'b0});
        end
        @(negedge apb_clk);
        vectors++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h12345678}) begin
            miscompares++;
            $display("FAIL rd_rsp_hold: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b0, 32'h12345678});
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0004;
        cmd_wdata = 32'h11111111; cmd_strb = 4'h3; PREADY = 1'b1;
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, PADDR, cmd_ready} !== {2'b10, 16'h0004, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_setup1: got %h expected %h", {PSEL, PENABLE, PADDR, cmd_ready}, {2'b10, 16'h0004, 1'b0});
        end
        cmd_addr = 16'h0008; cmd_wdata = 32'h22222222; cmd_strb = 4'hC;
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, PSTRB, cmd_ready} !== 7'b11_0011_1) begin
            miscompares++;
            $display("FAIL b2b_access1: got %b expected 1100111", {PSEL, PENABLE, PSTRB, cmd_ready});
        end
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        vectors++;
        if ({PSEL, PENABLE, rsp_valid, PADDR, PWDATA} !== {3'b101, 16'h0008, 32'h22222222}) begin
            miscompares++;
            $display("FAIL b2b_setup2: got %h expected %h", {PSEL, PENABLE, rsp_valid, PADDR, PWDATA}, {3'b101, 16'h0008, 32'h22222222});
        end
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, rsp_valid, PSTRB} !== 7'b110_1100) begin
            miscompares++;
            $display("FAIL b2b_access2: got %b expected 1101100", {PSEL, PENABLE, rsp_valid, PSTRB});
        end
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, rsp_valid, rsp_err} !== 4'b0010) begin
            miscompares++;
            $display("FAIL b2b_rsp2: got %b expected 0010", {PSEL, PENABLE, rsp_valid, rsp_err});
        end
    endtask

    task automatic test_slave_error();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h00F0;
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'hCAFEF00D;
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        @(negedge apb_clk);
        @(negedge apb_clk);
        PSLVERR = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL slverr_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b110, 32'hCAFEF00D});
        end
        @(negedge apb_clk);
    endtask

    task automatic test_timeout();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0100;
        PREADY = 1'b0; PRDATA = 32'h99999999;
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge apb_clk);
            vectors++;
            if ({PSEL, PENABLE, cmd_ready} !== 3'b110) begin
                miscompares++;
                $display("FAIL to_access%0d: got %b expected 110", i, {PSEL, PENABLE, cmd_ready});
            end
        end
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL to_release: got %b expected 000", {PSEL, PENABLE, busy});
        end
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b111, 32'h0}) begin
            miscompares++;
            $display("FAIL to_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b111, 32'h0});
        end
        @(negedge apb_clk);
        // PREADY on the fourth ACCESS cycle completes normally.
        cmd_valid = 1'b1; cmd_addr = 16'h0104;
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge apb_clk);
            if (i == 3) begin
                PREADY = 1'b1; PRDATA = 32'h0BADCAFE;
            end
        end
        @(negedge apb_clk);
        PREADY = 1'b0;
        vectors++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b100, 32'h0BADCAFE}) begin
            miscompares++;
            $display("FAIL to_edge_rsp: got %h expected %h", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {3'b100, 32'h0BADCAFE});
        end
        @(negedge apb_clk);
    endtask

    task automatic test_reset_mid_access();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0200;
        cmd_wdata = 32'h77777777; cmd_strb = 4'h1; PREADY = 1'b0;
        @(negedge apb_clk);
        cmd_valid = 1'b0;
        @(negedge apb_clk);
        vectors++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_pre: got %b expected 11", {PSEL, PENABLE});
        end
        apb_rst_n = 1'b0;
        #1;
        vectors++;
        if ({PSEL, PENABLE, rsp_valid, busy, PADDR} !== {4'b0000, 16'h0}) begin
            miscompares++;
            $display("FAIL rst_async: got %h expected 0", {PSEL, PENABLE, rsp_valid, busy, PADDR});
        end
        @(negedge apb_clk);
        apb_rst_n = 1'b1;
        @(negedge apb_clk);
        vectors++;
        if ({busy, cmd_ready, rsp_valid, PSEL} !== 4'b0100) begin
            miscompares++;
            $display("FAIL rst_after: got %b expected 0100", {busy, cmd_ready, rsp_valid, PSEL});
        end
        test_write();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_write();
        test_read_waits();
        test_back_to_back();
        test_slave_error();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
